// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPCODE  = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;

  localparam logic [1:0] ERR_CSUM    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte timeout: down-counter reloaded on every received byte,
// pulses o_expired for one cycle once TIMEOUT_CYCLES clocks pass idle.
module uart_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int              CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A byte in the same cycle always wins over expiry.
  assign o_expired = i_en && !i_clr && (cnt_q == '0);

  // Reload on byte or expiry, otherwise count down while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_expired) cnt_d = LOAD;
    else if (i_en)          cnt_d = cnt_q - CW'(1);
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= LOAD;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Command framer: SYNC, opcode, length, payload, XOR checksum.
// Presents validated commands over valid/ready; drops bad frames with
// a one-cycle error strobe and code. MAX_PAYLOAD is assumed < 256.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int         CLOCK_FREQUENCY = 25000000,
  parameter int         MAX_PAYLOAD     = 8,
  parameter logic [7:0] SYNC_BYTE       = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES  = 25000
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_rx_done,
  input  logic [7:0]                       i_rx_byte,
  input  logic                             i_cmd_ready,
  output logic                             o_cmd_valid,
  output logic [7:0]                       o_cmd_opcode,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0] o_cmd_len,
  output logic [8*MAX_PAYLOAD-1:0]         o_cmd_payload,
  output logic                             o_err,
  output logic [1:0]                       o_err_code
);

  localparam int LW = $clog2(MAX_PAYLOAD + 1);

  state_e                          state_q, state_d;
  logic [7:0]                      opcode_q, opcode_d;
  logic [LW-1:0]                   len_q, len_d;
  logic [LW-1:0]                   idx_q, idx_d;
  logic [MAX_PAYLOAD-1:0][7:0]     payload_q, payload_d;
  logic [7:0]                      csum_q, csum_d;
  logic                            err_q, err_d;
  logic [1:0]                      err_code_q, err_code_d;

  logic          is_sync, len_too_big, tmo_en, tmo;
  logic [LW-1:0] idx_inc;

  assign is_sync     = i_rx_done && (i_rx_byte == SYNC_BYTE);
  assign len_too_big = int'(i_rx_byte) > MAX_PAYLOAD;
  assign idx_inc     = idx_q + LW'(1);
  assign tmo_en      = (state_q == ST_OPCODE) || (state_q == ST_LEN) ||
                       (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

  uart_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (i_rx_done),
    .i_en     (tmo_en),
    .o_expired(tmo)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: bytes advance the frame, timeout aborts, handshake releases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (is_sync) state_d = ST_OPCODE;
      ST_OPCODE:  if (i_rx_done) state_d = ST_LEN;
                  else if (tmo) state_d = ST_IDLE;
      ST_LEN:     if (i_rx_done) begin
                    if (len_too_big)           state_d = ST_IDLE;
                    else if (i_rx_byte == '0)  state_d = ST_CSUM;
                    else                       state_d = ST_PAYLOAD;
                  end else if (tmo) state_d = ST_IDLE;
      ST_PAYLOAD: if (i_rx_done) begin
                    if (idx_inc == len_q) state_d = ST_CSUM;
                  end else if (tmo) state_d = ST_IDLE;
      ST_CSUM:    if (i_rx_done) state_d = (i_rx_byte == csum_q) ? ST_HOLD : ST_IDLE;
                  else if (tmo) state_d = ST_IDLE;
      ST_HOLD:    if (i_cmd_ready) state_d = is_sync ? ST_OPCODE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath and error strobe: capture fields, run checksum, flag faults.
  always_comb begin
    opcode_d   = opcode_q;
    len_d      = len_q;
    idx_d      = idx_q;
    payload_d  = payload_q;
    csum_d     = csum_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: if (is_sync) begin
        payload_d = '0;
        csum_d    = '0;
        idx_d     = '0;
      end
      ST_OPCODE: if (i_rx_done) begin
        opcode_d = i_rx_byte;
        csum_d   = csum_q ^ i_rx_byte;
      end else if (tmo) begin
        err_d = 1'b1; err_code_d = ERR_TIMEOUT;
      end
      ST_LEN: if (i_rx_done) begin
        if (len_too_big) begin
          err_d = 1'b1; err_code_d = ERR_LEN;
        end else begin
          len_d  = i_rx_byte[LW-1:0];
          csum_d = csum_q ^ i_rx_byte;
          idx_d  = '0;
        end
      end else if (tmo) begin
        err_d = 1'b1; err_code_d = ERR_TIMEOUT;
      end
      ST_PAYLOAD: if (i_rx_done) begin
        for (int k = 0; k < MAX_PAYLOAD; k++)
          if (idx_q == LW'(k)) payload_d[k] = i_rx_byte;
        csum_d = csum_q ^ i_rx_byte;
        idx_d  = idx_inc;
      end else if (tmo) begin
        err_d = 1'b1; err_code_d = ERR_TIMEOUT;
      end
      ST_CSUM: if (i_rx_done) begin
        if (i_rx_byte != csum_q) begin
          err_d = 1'b1; err_code_d = ERR_CSUM;
        end
      end else if (tmo) begin
        err_d = 1'b1; err_code_d = ERR_TIMEOUT;
      end
      ST_HOLD: if (i_cmd_ready) begin
        // Byte coinciding with the handshake is treated as if in IDLE.
        if (is_sync) begin
          payload_d = '0;
          csum_d    = '0;
          idx_d     = '0;
        end
      end else if (i_rx_done) begin
        err_d = 1'b1; err_code_d = ERR_OVERRUN;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      opcode_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      payload_q  <= '0;
      csum_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      opcode_q   <= opcode_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      payload_q  <= payload_d;
      csum_q     <= csum_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign o_cmd_valid   = (state_q == ST_HOLD);
  assign o_cmd_opcode  = opcode_q;
  assign o_cmd_len     = len_q;
  assign o_cmd_payload = payload_q;
  assign o_err         = err_q;
  assign o_err_code    = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected commands/errors queued
// at stimulus time, popped when the DUT hands them over.
module tb_uart_cmd_parser;

  localparam int MP = 8;
  localparam int TC = 64;
  localparam int LW = $clog2(MP + 1);

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_rx_done = 1'b0;
  logic [7:0]        i_rx_byte = 8'h00;
  logic              i_cmd_ready = 1'b0;
  logic              o_cmd_valid;
  logic [7:0]        o_cmd_opcode;
  logic [LW-1:0]     o_cmd_len;
  logic [8*MP-1:0]   o_cmd_payload;
  logic              o_err;
  logic [1:0]        o_err_code;

  typedef struct {
    logic [7:0]      op;
    logic [LW-1:0]   len;
    logic [8*MP-1:0] pl;
  } cmd_t;

  cmd_t       exp_cmd[$];
  logic [1:0] exp_err[$];
  cmd_t       mon_e;
  logic [1:0] mon_c;
  int         total = 0;
  int         bad = 0;
  int         cnt;

  uart_cmd_parser #(
    .CLOCK_FREQUENCY(25000000),
    .MAX_PAYLOAD    (MP),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx_done    (i_rx_done),
    .i_rx_byte    (i_rx_byte),
    .i_cmd_ready  (i_cmd_ready),
    .o_cmd_valid  (o_cmd_valid),
    .o_cmd_opcode (o_cmd_opcode),
    .o_cmd_len    (o_cmd_len),
    .o_cmd_payload(o_cmd_payload),
    .o_err        (o_err),
    .o_err_code   (o_err_code)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic send_byte(input logic [7:0] b);
    i_rx_done = 1'b1;
    i_rx_byte = b;
    @(posedge i_clk); #1;
    i_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic push_cmd(input logic [7:0] op, input int len, input logic [63:0] pl);
    cmd_t e;
    e.op  = op;
    e.len = LW'(len);
    e.pl  = pl;
    exp_cmd.push_back(e);
  endtask

  // Whole frame back-to-back; corrupt flips the checksum LSB.
  task automatic send_cmd(input logic [7:0] op, input int len, input logic [63:0] pl,
                          input bit corrupt);
    logic [7:0]  cs;
    logic [63:0] m;
    cs = op ^ 8'(len);
    m  = '0;
    send_byte(8'hA5);
    send_byte(op);
    send_byte(8'(len));
    for (int k = 0; k < len; k++) begin
      send_byte(pl[8*k +: 8]);
      cs = cs ^ pl[8*k +: 8];
      m[8*k +: 8] = pl[8*k +: 8];
    end
    if (corrupt) begin
      cs = cs ^ 8'h01;
      exp_err.push_back(2'd0);
    end else begin
      push_cmd(op, len, m);
    end
    send_byte(cs);
  endtask

  // Scoreboard monitor.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_cmd_valid && i_cmd_ready) begin
        if (exp_cmd.size() == 0) chk("unexp_cmd", 64'(o_cmd_valid), 64'd0);
        else begin
          mon_e = exp_cmd.pop_front();
          chk("cmd_op",  64'(o_cmd_opcode),  64'(mon_e.op));
          chk("cmd_len", 64'(o_cmd_len),     64'(mon_e.len));
          chk("cmd_pl",  64'(o_cmd_payload), 64'(mon_e.pl));
        end
      end
      if (o_err) begin
        if (exp_err.size() == 0) chk("unexp_err", 64'(o_err), 64'd0);
        else begin
          mon_c = exp_err.pop_front();
          chk("err_code", 64'(o_err_code), 64'(mon_c));
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid",  64'(o_cmd_valid),   64'd0);
    chk("rst_op",     64'(o_cmd_opcode),  64'd0);
    chk("rst_len",    64'(o_cmd_len),     64'd0);
    chk("rst_pl",     64'(o_cmd_payload), 64'd0);
    chk("rst_err",    64'(o_err),         64'd0);
    chk("rst_code",   64'(o_err_code),    64'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    idle(2);

    // Good frame held against a stalled consumer
    i_cmd_ready = 1'b0;
    send_cmd(8'h10, 2, 64'h2211, 1'b0);
    cnt = 0;
    repeat (5) begin @(negedge i_clk); cnt += int'(o_cmd_valid); @(posedge i_clk); #1; end
    i_cmd_ready = 1'b1;
    @(negedge i_clk); cnt += int'(o_cmd_valid);
    @(posedge i_clk); #1;
    i_cmd_ready = 1'b0;
    @(negedge i_clk);
    chk("valid_fall",  64'(o_cmd_valid), 64'd0);
    chk("hold_cycles", 64'(cnt),         64'd6);
    @(posedge i_clk); #1;

    // Bad checksum, then a good frame
    i_cmd_ready = 1'b1;
    send_cmd(8'h10, 2, 64'h2211, 1'b1);
    @(negedge i_clk);
    chk("csum_err",   64'(o_err),      64'd1);
    chk("csum_code",  64'(o_err_code), 64'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("csum_pulse", 64'(o_err),       64'd0);
    chk("csum_noval", 64'(o_cmd_valid), 64'd0);
    @(posedge i_clk); #1;
    send_cmd(8'h10, 2, 64'h2211, 1'b0);
    idle(3);

    // Oversize length, trailing junk ignored, then a full-size frame
    send_byte(8'hA5);
    send_byte(8'h10);
    exp_err.push_back(2'd1);
    send_byte(8'h09);
    @(negedge i_clk);
    chk("len_err",  64'(o_err),      64'd1);
    chk("len_code", 64'(o_err_code), 64'd1);
    @(posedge i_clk); #1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(3);
    send_cmd(8'h5C, 8, 64'h0807060504030201, 1'b0);
    idle(3);

    // Timeout fires exactly once
    send_byte(8'hA5);
    exp_err.push_back(2'd2);
    send_byte(8'h10);
    idle(TC - 1);
    @(negedge i_clk);
    chk("tmo_early", 64'(o_err), 64'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("tmo_err",  64'(o_err),      64'd1);
    chk("tmo_code", 64'(o_err_code), 64'd2);
    @(posedge i_clk); #1;
    idle(2 * TC);

    // Byte landing on the expiry cycle wins
    send_byte(8'hA5);
    send_byte(8'h10);
    idle(TC - 1);
    push_cmd(8'h10, 2, 64'h2211);
    send_byte(8'h02);
    @(negedge i_clk);
    chk("tmo_win", 64'(o_err), 64'd0);
    @(posedge i_clk); #1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
    idle(3);

    // Overrun while held, then handshake coinciding with SYNC
    i_cmd_ready = 1'b0;
    send_cmd(8'h33, 1, 64'h44, 1'b0);
    exp_err.push_back(2'd3);
    send_byte(8'h55);
    @(negedge i_clk);
    chk("ovr_err",   64'(o_err),         64'd1);
    chk("ovr_code",  64'(o_err_code),    64'd3);
    chk("ovr_valid", 64'(o_cmd_valid),   64'd1);
    chk("ovr_op",    64'(o_cmd_opcode),  64'h33);
    chk("ovr_pl",    64'(o_cmd_payload), 64'h44);
    @(posedge i_clk); #1;
    i_cmd_ready = 1'b1;
    send_byte(8'hA5);
    push_cmd(8'h07, 0, 64'h0);
    send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    idle(3);

    // Reset mid-payload
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'hAA);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("mrst_valid", 64'(o_cmd_valid),   64'd0);
    chk("mrst_op",    64'(o_cmd_opcode),  64'd0);
    chk("mrst_len",   64'(o_cmd_len),     64'd0);
    chk("mrst_pl",    64'(o_cmd_payload), 64'd0);
    chk("mrst_err",   64'(o_err),         64'd0);
    @(posedge i_clk); #1;
    idle(2);
    send_cmd(8'h20, 1, 64'h5A, 1'b0);
    idle(5);

    chk("cmd_left", 64'(exp_cmd.size()), 64'd0);
    chk("err_left", 64'(exp_err.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
